// File: rtl/alu_req_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_req_sequencer
//  Purpose  : Two-port round-robin arbiter and sequencer for the shared ALU /
//             mul8x8 datapath. Grants one request at a time, drives registered
//             operands into the ALU, waits the per-opcode latency, captures
//             the result/flags and returns them with a one-cycle done pulse.
//  Ports    : clk_in, rst_in (async, active-high)
//             reqN_valid_in/op_in/a_in/b_in/sz_in/ccr_in   request fields
//             reqN_ack_out  (1-cycle accept pulse), reqN_done_out (1-cycle)
//             alu_a/b/op/sz/ccr_out  registered drive into the ALU
//             alu_q_in, alu_ccr_in   ALU result and flags
//             res_q_out, res_ccr_out captured result (held until next capture)
//             busy_out               high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module alu_req_sequencer #(
    parameter int          LAT_ALU = 1,
    parameter int          LAT_MUL = 3,
    parameter logic [4:0]  MUL_OP  = 5'h10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req0_valid_in,
    input  logic [4:0]  req0_op_in,
    input  logic [15:0] req0_a_in,
    input  logic [15:0] req0_b_in,
    input  logic        req0_sz_in,
    input  logic [7:0]  req0_ccr_in,
    output logic        req0_ack_out,
    output logic        req0_done_out,
    input  logic        req1_valid_in,
    input  logic [4:0]  req1_op_in,
    input  logic [15:0] req1_a_in,
    input  logic [15:0] req1_b_in,
    input  logic        req1_sz_in,
    input  logic [7:0]  req1_ccr_in,
    output logic        req1_ack_out,
    output logic        req1_done_out,
    output logic [15:0] alu_a_out,
    output logic [15:0] alu_b_out,
    output logic [4:0]  alu_op_out,
    output logic        alu_sz_out,
    output logic [7:0]  alu_ccr_out,
    input  logic [15:0] alu_q_in,
    input  logic [7:0]  alu_ccr_in,
    output logic [15:0] res_q_out,
    output logic [7:0]  res_ccr_out,
    output logic        busy_out
);

    localparam logic [2:0] C_LAT_ALU = 3'(LAT_ALU);
    localparam logic [2:0] C_LAT_MUL = 3'(LAT_MUL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr;       // last granted port; the other port wins a tie
    logic        r_grant;
    logic [2:0]  r_cnt;
    logic        r_ack0, r_ack1, r_done0, r_done1;
    logic [15:0] r_alu_a, r_alu_b;
    logic [4:0]  r_alu_op;
    logic        r_alu_sz;
    logic [7:0]  r_alu_ccr;
    logic [15:0] r_res_q;
    logic [7:0]  r_res_ccr;

    logic        w_any;
    logic        w_port;
    logic [4:0]  w_op;
    logic [15:0] w_a, w_b;
    logic        w_sz;
    logic [7:0]  w_ccr;
    logic [2:0]  w_lat;

    // Single requester takes it; on a tie the port that did not win last time.
    // ~valid0 yields 1 only when port 1 is the lone requester.
    assign w_any  = req0_valid_in | req1_valid_in;
    assign w_port = (req0_valid_in & req1_valid_in) ? ~r_rr : ~req0_valid_in;

    assign w_op  = w_port ? req1_op_in  : req0_op_in;
    assign w_a   = w_port ? req1_a_in   : req0_a_in;
    assign w_b   = w_port ? req1_b_in   : req0_b_in;
    assign w_sz  = w_port ? req1_sz_in  : req0_sz_in;
    assign w_ccr = w_port ? req1_ccr_in : req0_ccr_in;
    assign w_lat = (w_op == MUL_OP) ? C_LAT_MUL : C_LAT_ALU;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b1;
            r_grant   <= 1'b0;
            r_cnt     <= 3'd0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_alu_a   <= 16'h0000;
            r_alu_b   <= 16'h0000;
            r_alu_op  <= 5'h00;
            r_alu_sz  <= 1'b0;
            r_alu_ccr <= 8'h00;
            r_res_q   <= 16'h0000;
            r_res_ccr <= 8'h00;
        end else begin
            // Handshake strobes are single-cycle by default.
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_alu_op  <= w_op;
                        r_alu_sz  <= w_sz;
                        r_alu_ccr <= w_ccr;
                        r_grant   <= w_port;
                        r_rr      <= w_port;
                        r_cnt     <= w_lat;
                        r_ack0    <= ~w_port;
                        r_ack1    <= w_port;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_res_q   <= alu_q_in;
                        r_res_ccr <= alu_ccr_in;
                        r_done0   <= ~r_grant;
                        r_done1   <= r_grant;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ack_out  = r_ack0;
    assign req1_ack_out  = r_ack1;
    assign req0_done_out = r_done0;
    assign req1_done_out = r_done1;
    assign alu_a_out     = r_alu_a;
    assign alu_b_out     = r_alu_b;
    assign alu_op_out    = r_alu_op;
    assign alu_sz_out    = r_alu_sz;
    assign alu_ccr_out   = r_alu_ccr;
    assign res_q_out     = r_res_q;
    assign res_ccr_out   = r_res_ccr;
    assign busy_out      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_req_sequencer
//  Purpose  : Scoreboard bench for alu_req_sequencer with a behavioural ALU
//             model, directed scenarios and randomized two-port traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_req_sequencer;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_AND = 5'h02;
    localparam logic [4:0] OP_OR  = 5'h03;
    localparam logic [4:0] OP_EOR = 5'h04;
    localparam logic [4:0] OP_MUL = 5'h10;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        req0_valid_in = 1'b0, req1_valid_in = 1'b0;
    logic [4:0]  req0_op_in = '0, req1_op_in = '0;
    logic [15:0] req0_a_in = '0, req0_b_in = '0, req1_a_in = '0, req1_b_in = '0;
    logic        req0_sz_in = 1'b0, req1_sz_in = 1'b0;
    logic [7:0]  req0_ccr_in = '0, req1_ccr_in = '0;
    logic        req0_ack_out, req0_done_out, req1_ack_out, req1_done_out;
    logic [15:0] alu_a_out, alu_b_out, alu_q_in, res_q_out;
    logic [4:0]  alu_op_out;
    logic        alu_sz_out, busy_out;
    logic [7:0]  alu_ccr_out, alu_ccr_in, res_ccr_out;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sz;
        logic [7:0]  ccr;
        logic [15:0] q;
        logic [7:0]  f;
        int          lat;
    } exp_t;

    exp_t expq0[$];
    exp_t expq1[$];
    exp_t cur_e[2];
    bit   pend[2];
    int   ack_cyc[2];
    int   ack_log_port[$];
    int   ack_log_cyc[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_grant = 1;
    bit   force_q  = 1'b0;
    logic [1:0] v_edge = 2'b00;

    alu_req_sequencer #(.LAT_ALU(1), .LAT_MUL(3), .MUL_OP(OP_MUL)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req0_valid_in(req0_valid_in), .req0_op_in(req0_op_in), .req0_a_in(req0_a_in),
        .req0_b_in(req0_b_in), .req0_sz_in(req0_sz_in), .req0_ccr_in(req0_ccr_in),
        .req0_ack_out(req0_ack_out), .req0_done_out(req0_done_out),
        .req1_valid_in(req1_valid_in), .req1_op_in(req1_op_in), .req1_a_in(req1_a_in),
        .req1_b_in(req1_b_in), .req1_sz_in(req1_sz_in), .req1_ccr_in(req1_ccr_in),
        .req1_ack_out(req1_ack_out), .req1_done_out(req1_done_out),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
        .alu_sz_out(alu_sz_out), .alu_ccr_out(alu_ccr_out),
        .alu_q_in(alu_q_in), .alu_ccr_in(alu_ccr_in),
        .res_q_out(res_q_out), .res_ccr_out(res_ccr_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural ALU: {flags, q}
    function automatic logic [23:0] alu_ref(input logic [4:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic sz,
                                            input logic [7:0] ccr);
        logic [16:0] r;
        logic [15:0] q;
        logic        c;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_MUL:  r = 17'(a[7:0]) * 17'(b[7:0]);
            default: r = {1'b0, a ^ b};
        endcase
        if (op == OP_MUL) begin
            q = r[15:0];
            c = 1'b0;
        end else if (sz) begin
            q = r[15:0];
            c = r[16];
        end else begin
            q = {a[15:8], r[7:0]};
            c = r[8];
        end
        return {ccr[7:4], q[15], (q == 16'h0000), 1'b0, c, q};
    endfunction

    logic [23:0] w_alu;
    always_comb begin
        w_alu      = alu_ref(alu_op_out, alu_a_out, alu_b_out, alu_sz_out, alu_ccr_out);
        alu_q_in   = force_q ? 16'hFFFF : w_alu[15:0];
        alu_ccr_in = w_alu[23:16];
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk(act == req, nm, act, req);
    endtask

    function automatic logic [74:0] all_outs();
        return {req0_ack_out, req0_done_out, req1_ack_out, req1_done_out, busy_out,
                alu_a_out, alu_b_out, alu_op_out, alu_sz_out, alu_ccr_out,
                res_q_out, res_ccr_out};
    endfunction

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 6))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_EOR;
            5: return OP_MUL;
            default: return 5'h1F;
        endcase
    endfunction

    // Raise a request, hold until ack, then drop. nwait = negedges until ack seen.
    task automatic issue(input int p, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic sz, input logic [7:0] ccr,
                         output int nwait);
        exp_t        e;
        logic [23:0] r;
        bit          got;
        r     = alu_ref(op, a, b, sz, ccr);
        e.op  = op;  e.a = a;  e.b = b;  e.sz = sz;  e.ccr = ccr;
        e.q   = r[15:0];
        e.f   = r[23:16];
        e.lat = (op == OP_MUL) ? 3 : 1;
        @(posedge clk_in); #1;
        if (p == 0) begin
            req0_op_in = op; req0_a_in = a; req0_b_in = b; req0_sz_in = sz; req0_ccr_in = ccr;
            req0_valid_in = 1'b1;
            expq0.push_back(e);
        end else begin
            req1_op_in = op; req1_a_in = a; req1_b_in = b; req1_sz_in = sz; req1_ccr_in = ccr;
            req1_valid_in = 1'b1;
            expq1.push_back(e);
        end
        got   = 1'b0;
        nwait = 0;
        while (!got && nwait < 200) begin
            @(negedge clk_in);
            nwait++;
            got = (p == 0) ? req0_ack_out : req1_ack_out;
        end
        chk(got, "ack_timeout", 32'(p), 32'(1));
        if (!got) begin
            if (p == 0) void'(expq0.pop_back());
            else        void'(expq1.pop_back());
        end
        @(posedge clk_in); #1;
        if (p == 0) req0_valid_in = 1'b0;
        else        req1_valid_in = 1'b0;
    endtask

    task automatic wait_idle(output int nbusy);
        bit idle;
        idle  = 1'b0;
        nbusy = 0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk_in);
            if (busy_out) nbusy++;
            else          idle = 1'b1;
        end
        chk(idle, "idle_timeout", 32'(busy_out), 32'(0));
    endtask

    // Monitor / scoreboard
    always @(negedge clk_in) begin
        logic [1:0] ack;
        logic [1:0] done;
        bit         has;
        exp_t       e;
        ack  = {req1_ack_out, req0_ack_out};
        done = {req1_done_out, req0_done_out};
        if (!rst_in) begin
            if (ack != 2'b00)  chk(ack != 2'b11, "ack_overlap", 32'(ack), 32'(0));
            if (done != 2'b00) chk(done != 2'b11, "done_overlap", 32'(done), 32'(0));
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    chk(!done[p], "ack_done_same_port", 32'(p), 32'(0));
                    chk(v_edge[p], "ack_without_valid", 32'(p), 32'(1));
                    if (v_edge == 2'b11) chk_eq("rr_grant", 32'(p), 32'(1 - last_grant));
                    last_grant = p;
                    ack_log_port.push_back(p);
                    ack_log_cyc.push_back(cyc);
                    chk(busy_out, "busy_at_ack", 32'(busy_out), 32'(1));
                    has = (p == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
                    chk(has, "ack_has_request", 32'(p), 32'(1));
                    if (has) begin
                        e = (p == 0) ? expq0[0] : expq1[0];
                        chk_eq("alu_a_drive", 32'(alu_a_out), 32'(e.a));
                        chk_eq("alu_b_drive", 32'(alu_b_out), 32'(e.b));
                        chk_eq("alu_op_sz_ccr_drive", 32'({alu_op_out, alu_sz_out, alu_ccr_out}),
                               32'({e.op, e.sz, e.ccr}));
                        pend[p]    = 1'b1;
                        ack_cyc[p] = cyc;
                        cur_e[p]   = e;
                    end
                end
                if (done[p]) begin
                    chk(pend[p], "done_pending", 32'(p), 32'(1));
                    if (pend[p]) begin
                        e = cur_e[p];
                        if (p == 0) void'(expq0.pop_front());
                        else        void'(expq1.pop_front());
                        chk_eq("res_q", 32'(res_q_out), 32'(e.q));
                        chk_eq("res_ccr", 32'(res_ccr_out), 32'(e.f));
                        chk_eq("done_latency", 32'(cyc - ack_cyc[p]), 32'(e.lat));
                        chk_eq("alu_a_held", 32'(alu_a_out), 32'(e.a));
                        pend[p] = 1'b0;
                    end
                end
            end
        end
        v_edge = {req1_valid_in, req0_valid_in};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nb, nd;
        // Reset state
        #1 rst_in = 1'b1;
        #2 chk(all_outs() == 75'd0, "reset_outputs", 32'(all_outs()), 32'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Single port 0 ADD, 8-bit
        issue(0, OP_ADD, 16'h0012, 16'h0034, 1'b0, 8'h00, nw);
        chk_eq("add_ack_delay", 32'(nw), 32'(2));
        wait_idle(nb);
        chk_eq("add_result", 32'(res_q_out), 32'h0046);
        chk_eq("add_busy_cycles", 32'(nb + 1), 32'(2));

        // MUL latency on port 1
        issue(1, OP_MUL, 16'h0007, 16'h0009, 1'b0, 8'h0F, nw);
        chk_eq("mul_ack_delay", 32'(nw), 32'(2));
        wait_idle(nb);
        chk_eq("mul_result", 32'(res_q_out), 32'h003F);
        chk_eq("mul_busy_cycles", 32'(nb + 1), 32'(4));

        // Result hold while the ALU output changes
        force_q = 1'b1;
        repeat (4) @(negedge clk_in);
        chk_eq("result_hold", 32'(res_q_out), 32'h003F);
        force_q = 1'b0;

        // Both ports held valid: alternate grants spaced LAT+2
        ack_log_port.delete();
        ack_log_cyc.delete();
        fork
            begin
                issue(0, OP_ADD, 16'h1234, 16'h1111, 1'b1, 8'hA0, nw);
                issue(0, OP_SUB, 16'h0100, 16'h0001, 1'b1, 8'h50, nw);
            end
            begin
                issue(1, OP_OR,  16'hF000, 16'h000F, 1'b1, 8'h30, nd);
                issue(1, OP_AND, 16'hFF00, 16'h0FF0, 1'b0, 8'hC0, nd);
            end
        join
        wait_idle(nb);
        chk_eq("rr_log_size", 32'(ack_log_port.size()), 32'(4));
        for (int i = 0; i < 4 && i < ack_log_port.size(); i++) begin
            chk_eq("rr_order", 32'(ack_log_port[i]), 32'(i % 2));
            if (i > 0) chk_eq("rr_spacing", 32'(ack_log_cyc[i] - ack_log_cyc[i-1]), 32'(3));
        end

        // Port 1 request while port 0 MUL is in flight
        ack_log_port.delete();
        ack_log_cyc.delete();
        fork
            issue(0, OP_MUL, 16'h00FF, 16'h00FF, 1'b1, 8'h00, nw);
            begin
                repeat (2) @(posedge clk_in);
                issue(1, OP_ADD, 16'h00F0, 16'h0020, 1'b0, 8'h10, nd);
            end
        join
        wait_idle(nb);
        chk_eq("busy_req_log_size", 32'(ack_log_port.size()), 32'(2));
        if (ack_log_port.size() == 2) begin
            chk_eq("busy_req_order", 32'(ack_log_port[1]), 32'(1));
            chk_eq("busy_req_spacing", 32'(ack_log_cyc[1] - ack_log_cyc[0]), 32'(5));
        end

        // Reset during WAIT of a port 0 MUL; afterwards port 0 must win a tie
        issue(0, OP_MUL, 16'h0003, 16'h0005, 1'b0, 8'h00, nw);
        #2 rst_in = 1'b1;
        #1 chk(all_outs() == 75'd0, "midop_reset_outputs", 32'(all_outs()), 32'(0));
        if (expq0.size() > 0) void'(expq0.pop_front());
        pend[0]    = 1'b0;
        last_grant = 1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        ack_log_port.delete();
        ack_log_cyc.delete();
        fork
            issue(0, OP_EOR, 16'h5555, 16'hAAAA, 1'b1, 8'h00, nw);
            issue(1, OP_ADD, 16'h0001, 16'h0001, 1'b1, 8'h00, nd);
        join
        wait_idle(nb);
        chk_eq("post_reset_log_size", 32'(ack_log_port.size()), 32'(2));
        if (ack_log_port.size() > 0)
            chk_eq("post_reset_first_grant", 32'(ack_log_port[0]), 32'(0));

        // Randomized two-port traffic
        fork
            begin
                int w0;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_in);
                    issue(0, rand_op(), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          8'($urandom), w0);
                end
            end
            begin
                int w1;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_in);
                    issue(1, rand_op(), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          8'($urandom), w1);
                end
            end
        join
        wait_idle(nb);
        repeat (3) @(negedge clk_in);
        chk_eq("final_queue0_empty", 32'(expq0.size()), 32'(0));
        chk_eq("final_queue1_empty", 32'(expq1.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
